// File: rtl/mmu_ws_pkg.sv
// Shared encodings for the wait-state MMU: fault codes, access sizes,
// FSM state encoding and default address map.
package mmu_ws_pkg;

  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_NONE     = 2'd0;
  localparam fault_t FAULT_MISALIGN = 2'd1;
  localparam fault_t FAULT_UNMAPPED = 2'd2;
  localparam fault_t FAULT_TIMEOUT  = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IO_WAIT = 2'd1;
  localparam logic [1:0] ST_IO_DONE = 2'd2;

  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
  localparam logic [31:0] RAM_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] IO_BASE_DEF  = 32'h8000_0000;

endpackage

// File: rtl/mmu_ws_if.sv
// Pipeline/memory-side signal bundle of the MMU. The MMU uses the slave
// view; the pipeline, ROM and IO bank together form the master view.
interface mmu_ws_if #(
  parameter int IO_ADDR_W = 8
);
  logic [31:0]          im_addr;
  logic [9:0]           im_addr_out;
  logic [31:0]          im_data;
  logic [31:0]          im_do;
  logic                 dm_req;
  logic                 dm_we;
  logic [31:0]          dm_addr;
  logic [1:0]           dm_size;
  logic                 is_signed;
  logic [31:0]          dm_di;
  logic [31:0]          dm_do;
  logic                 dm_valid;
  logic [1:0]           dm_fault;
  logic                 dm_stall;
  logic [IO_ADDR_W-1:0] io_addr;
  logic                 io_en;
  logic                 io_we;
  logic [3:0]           io_be;
  logic [31:0]          io_data_write;
  logic [31:0]          io_data_read;
  logic                 io_ready;

  modport slave (
    input  im_addr, im_data, dm_req, dm_we, dm_addr, dm_size, is_signed, dm_di,
           io_data_read, io_ready,
    output im_addr_out, im_do, dm_do, dm_valid, dm_fault, dm_stall,
           io_addr, io_en, io_we, io_be, io_data_write
  );

  modport master (
    output im_addr, im_data, dm_req, dm_we, dm_addr, dm_size, is_signed, dm_di,
           io_data_read, io_ready,
    input  im_addr_out, im_do, dm_do, dm_valid, dm_fault, dm_stall,
           io_addr, io_en, io_we, io_be, io_data_write
  );
endinterface

// File: rtl/bram_ssp.sv
// Single-port synchronous RAM, read-before-write, one cycle read latency.
module BRAM_SSP #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= din_i;
      dout_o <= mem[addr_i];
    end
  end
endmodule

// File: rtl/mmu_ws_align.sv
// Byte-lane helper: size/offset to byte enables and alignment, store lane
// replication, and load lane selection with zero/sign extension.
module mmu_ws_align
  import mmu_ws_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic        misaligned_o,
  output logic [31:0] st_lanes_o,
  input  logic [31:0] ld_word_i,
  input  logic [3:0]  ld_be_i,
  input  logic        ld_signed_i,
  output logic [31:0] ld_data_o
);
  always_comb begin
    be_o         = 4'b0000;
    misaligned_o = 1'b0;
    st_lanes_o   = st_data_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o       = 4'b0001 << addr_lo_i;
        st_lanes_o = {4{st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        misaligned_o = addr_lo_i[0];
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_lanes_o   = {2{st_data_i[15:0]}};
      end
      SIZE_WORD: begin
        misaligned_o = |addr_lo_i;
        be_o         = 4'b1111;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

  // The registered byte enables fully describe which lanes hold the datum.
  always_comb begin
    ld_data_o = 32'd0;
    case (ld_be_i)
      4'b0001: ld_data_o = {{24{ld_signed_i & ld_word_i[7]}},  ld_word_i[7:0]};
      4'b0010: ld_data_o = {{24{ld_signed_i & ld_word_i[15]}}, ld_word_i[15:8]};
      4'b0100: ld_data_o = {{24{ld_signed_i & ld_word_i[23]}}, ld_word_i[23:16]};
      4'b1000: ld_data_o = {{24{ld_signed_i & ld_word_i[31]}}, ld_word_i[31:24]};
      4'b0011: ld_data_o = {{16{ld_signed_i & ld_word_i[15]}}, ld_word_i[15:0]};
      4'b1100: ld_data_o = {{16{ld_signed_i & ld_word_i[31]}}, ld_word_i[31:16]};
      4'b1111: ld_data_o = ld_word_i;
      default: ld_data_o = 32'd0;
    endcase
  end
endmodule

// File: rtl/mmu_ws.sv
// MMU with ROM passthrough, 4-bank byte RAM and a wait-state IO window.
// state      | meaning
// IDLE       | RAM/fault requests answered next cycle; IO request stalls and launches
// IO_WAIT    | IO access in flight, pipeline stalled, counting toward timeout
// IO_DONE    | held IO request accepted, response (data or timeout) next cycle
module mmu_ws
  import mmu_ws_pkg::*;
#(
  parameter int          WORD_DEPTH     = 1024,
  parameter int          WORD_DEPTH_LOG = 10,
  parameter logic [31:0] RAM_BASE       = RAM_BASE_DEF,
  parameter logic [31:0] IO_BASE        = IO_BASE_DEF,
  parameter int          IO_ADDR_W      = 8,
  parameter int          IO_TIMEOUT     = 255
) (
  input logic     clk,
  input logic     resetb,
  mmu_ws_if.slave bus
);
  localparam logic [15:0] TO_LAST = 16'(IO_TIMEOUT - 1);

  logic [31:0] ram_off, io_off, st_lanes, ram_rdata, ld_word, ld_data, im_do_q;
  logic        in_ram, in_io, misaligned, io_hit, stall, accept, ram_en;
  logic [3:0]  be;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        io_en_q, io_en_d, io_we_q, io_we_d, to_fault_q, to_fault_d;
  logic [3:0]  io_be_q, io_be_d;
  logic [IO_ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [31:0] io_wdata_q, io_wdata_d, io_rdata_q, io_rdata_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_load_q, rsp_load_d;
  logic        rsp_ram_q, rsp_ram_d, rsp_signed_q, rsp_signed_d;
  fault_t      rsp_fault_q, rsp_fault_d;
  logic [3:0]  rsp_be_q, rsp_be_d;

  assign ram_off = bus.dm_addr - RAM_BASE;
  assign io_off  = bus.dm_addr - IO_BASE;
  assign in_ram  = (ram_off >> WORD_DEPTH_LOG) == 32'd0;
  assign in_io   = (io_off >> IO_ADDR_W) == 32'd0;
  assign io_hit  = bus.dm_req & ~misaligned & ~in_ram & in_io;

  mmu_ws_align u_align (
    .size_i      (bus.dm_size),
    .addr_lo_i   (bus.dm_addr[1:0]),
    .st_data_i   (bus.dm_di),
    .be_o        (be),
    .misaligned_o(misaligned),
    .st_lanes_o  (st_lanes),
    .ld_word_i   (ld_word),
    .ld_be_i     (rsp_be_q),
    .ld_signed_i (rsp_signed_q),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    stall  = 1'b0;
    accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall  = io_hit;
        accept = bus.dm_req & ~io_hit;
      end
      ST_IO_WAIT: stall  = 1'b1;
      ST_IO_DONE: accept = bus.dm_req;
      default: ;
    endcase
  end

  assign ram_en = accept & (state_q == ST_IDLE) & ~misaligned & in_ram;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    BRAM_SSP #(.WIDTH(8), .DEPTH(WORD_DEPTH >> 2)) u_bank (
      .clk   (clk),
      .en_i  (ram_en & be[b]),
      .we_i  (bus.dm_we),
      .addr_i(ram_off[WORD_DEPTH_LOG-1:2]),
      .din_i (st_lanes[8*b +: 8]),
      .dout_o(ram_rdata[8*b +: 8])
    );
  end

  always_comb begin
    rsp_valid_d  = accept;
    rsp_fault_d  = FAULT_NONE;
    rsp_ram_d    = 1'b0;
    rsp_load_d   = accept & ~bus.dm_we;
    rsp_be_d     = rsp_be_q;
    rsp_signed_d = rsp_signed_q;
    if (accept) begin
      rsp_be_d     = be;
      rsp_signed_d = bus.is_signed;
      if (state_q == ST_IO_DONE) rsp_fault_d = to_fault_q ? FAULT_TIMEOUT : FAULT_NONE;
      else if (misaligned)       rsp_fault_d = FAULT_MISALIGN;
      else if (in_ram)           rsp_ram_d   = 1'b1;
      else                       rsp_fault_d = FAULT_UNMAPPED;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    io_en_d    = io_en_q;
    io_we_d    = io_we_q;
    io_be_d    = io_be_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_rdata_d = io_rdata_q;
    to_fault_d = to_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (io_hit) begin
          state_d    = ST_IO_WAIT;
          io_en_d    = 1'b1;
          io_we_d    = bus.dm_we;
          io_be_d    = be;
          io_addr_d  = io_off[IO_ADDR_W-1:0];
          io_wdata_d = st_lanes;
          cnt_d      = 16'd0;
          to_fault_d = 1'b0;
        end
      end
      ST_IO_WAIT: begin
        // A ready arriving on the last counted cycle still completes normally.
        if (bus.io_ready) begin
          io_rdata_d = bus.io_data_read;
          io_en_d    = 1'b0;
          state_d    = ST_IO_DONE;
        end else if (cnt_q == TO_LAST) begin
          io_en_d    = 1'b0;
          to_fault_d = 1'b1;
          state_d    = ST_IO_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      im_do_q      <= NOP_INSN;
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      io_en_q      <= 1'b0;
      io_we_q      <= 1'b0;
      io_be_q      <= 4'd0;
      io_addr_q    <= '0;
      io_wdata_q   <= 32'd0;
      io_rdata_q   <= 32'd0;
      to_fault_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_fault_q  <= FAULT_NONE;
      rsp_ram_q    <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_be_q     <= 4'd0;
      rsp_signed_q <= 1'b0;
    end else begin
      im_do_q      <= bus.im_data;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      io_en_q      <= io_en_d;
      io_we_q      <= io_we_d;
      io_be_q      <= io_be_d;
      io_addr_q    <= io_addr_d;
      io_wdata_q   <= io_wdata_d;
      io_rdata_q   <= io_rdata_d;
      to_fault_q   <= to_fault_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_fault_q  <= rsp_fault_d;
      rsp_ram_q    <= rsp_ram_d;
      rsp_load_q   <= rsp_load_d;
      rsp_be_q     <= rsp_be_d;
      rsp_signed_q <= rsp_signed_d;
    end
  end

  assign ld_word           = rsp_ram_q ? ram_rdata : io_rdata_q;
  assign bus.im_addr_out   = bus.im_addr[11:2];
  assign bus.im_do         = im_do_q;
  assign bus.dm_do         = (rsp_valid_q && rsp_load_q && rsp_fault_q == FAULT_NONE) ? ld_data : 32'd0;
  assign bus.dm_valid      = rsp_valid_q;
  assign bus.dm_fault      = rsp_fault_q;
  assign bus.dm_stall      = stall & resetb;
  assign bus.io_addr       = io_addr_q;
  assign bus.io_en         = io_en_q;
  assign bus.io_we         = io_we_q;
  assign bus.io_be         = io_be_q;
  assign bus.io_data_write = io_wdata_q;
endmodule

// File: tb/tb_mmu_ws.sv
// Transaction-level reference model of the MMU driven with random and
// directed accesses; a negedge process compares every cycle.
module tb_mmu_ws;
  import mmu_ws_pkg::*;

  localparam int          TO = 4;
  localparam logic [31:0] RB = 32'h1000_0000;
  localparam logic [31:0] IB = 32'h8000_0000;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  mmu_ws_if #(.IO_ADDR_W(8)) bus ();

  mmu_ws #(
    .WORD_DEPTH(1024), .WORD_DEPTH_LOG(10), .RAM_BASE(RB), .IO_BASE(IB),
    .IO_ADDR_W(8), .IO_TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetb(resetb), .bus(bus)
  );

  int n_chk = 0, n_err = 0;
  int stall_cnt = 0, ioen_cnt = 0, valid_cnt = 0;
  logic [7:0]  mem [1024];
  bit          exp_valid, exp_stall, exp_io_en, exp_io_chk, pend_v;
  logic [1:0]  exp_fault, pend_f;
  logic [31:0] exp_do, pend_d, prev_im;
  logic [7:0]  exp_io_addr;
  logic        exp_io_we;
  logic [3:0]  exp_io_be;
  logic [31:0] exp_io_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] v, input int n, input bit s);
    logic [31:0] m, r;
    if (n == 4) return v;
    m = (32'd1 << (8 * n)) - 32'd1;
    r = v & m;
    if (s && r[8*n-1]) r = r | ~m;
    return r;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(negedge clk) begin
    if (!resetb) begin
      prev_im = NOP_INSN;
    end else begin
      chk("im_do", bus.im_do, prev_im);
      chk("im_addr_out", {22'd0, bus.im_addr_out}, {22'd0, bus.im_addr[11:2]});
      chk("dm_stall", 32'(bus.dm_stall), 32'(exp_stall));
      chk("io_en", 32'(bus.io_en), 32'(exp_io_en));
      chk("dm_valid", 32'(bus.dm_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("dm_fault", 32'(bus.dm_fault), 32'(exp_fault));
        chk("dm_do", bus.dm_do, exp_do);
      end
      if (exp_io_chk) begin
        chk("io_addr", 32'(bus.io_addr), 32'(exp_io_addr));
        chk("io_we", 32'(bus.io_we), 32'(exp_io_we));
        chk("io_be", 32'(bus.io_be), 32'(exp_io_be));
        if (exp_io_we)
          chk("io_data_write", bus.io_data_write & lane_mask(exp_io_be),
              exp_io_wd & lane_mask(exp_io_be));
      end
      stall_cnt += int'(bus.dm_stall);
      ioen_cnt  += int'(bus.io_en);
      valid_cnt += int'(bus.dm_valid);
      prev_im = bus.im_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_valid = pend_v;
    exp_fault = pend_f;
    exp_do    = pend_d;
    pend_v    = 1'b0;
    exp_stall = 1'b0;
    exp_io_en = 1'b0;
    exp_io_chk = 1'b0;
    bus.im_addr      = $urandom;
    bus.im_data      = $urandom;
    bus.io_ready     = 1'($urandom_range(0, 1));
    bus.io_data_read = $urandom;
  endtask

  task automatic idle();
    step();
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'($urandom_range(0, 1));
    bus.dm_addr   = $urandom_range(0, 1) ? (IB + 32'($urandom_range(0, 255))) : $urandom;
    bus.dm_size   = 2'($urandom_range(0, 3));
    bus.is_signed = 1'($urandom_range(0, 1));
    bus.dm_di     = $urandom;
  endtask

  // rdy_at: IO wait cycle (1-based) carrying io_ready, 0 = never.
  // rst_at: IO wait cycle in which reset is asserted, 0 = none.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                     input bit sgn, input logic [31:0] data, input int rdy_at, input int rst_at);
    int n, lane;
    logic [31:0] off, ioff, v, rd;
    logic [1:0] f;
    bit mis;
    step();
    bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_size = size;
    bus.is_signed = sgn; bus.dm_di = data;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lane = int'(addr[1:0]);
    mis  = (size == 2'd3) || ((addr % n) != 0);
    off  = addr - RB;
    ioff = addr - IB;
    v = 32'd0;
    f = 2'd0;
    if (mis) begin
      f = 2'd1;
    end else if (off < 32'd1024) begin
      if (we) for (int i = 0; i < n; i++) mem[int'(off) + i] = data[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) v = v | (32'(mem[int'(off) + i]) << (8 * i));
        v = ext(v, n, sgn);
      end
    end else if (ioff < 32'd256) begin
      exp_stall   = 1'b1;
      exp_io_addr = ioff[7:0];
      exp_io_we   = we;
      exp_io_be   = 4'(((1 << n) - 1) << lane);
      exp_io_wd   = data << (8 * lane);
      rd = $urandom;
      f  = 2'd3;
      for (int w = 1; w <= TO; w++) begin
        step();
        exp_stall = 1'b1; exp_io_en = 1'b1; exp_io_chk = 1'b1;
        bus.io_ready     = (w == rdy_at);
        bus.io_data_read = rd;
        if (w == rst_at) begin
          #1 resetb = 1'b0;
          #1;
          chk("rst io_en", 32'(bus.io_en), 32'd0);
          chk("rst dm_valid", 32'(bus.dm_valid), 32'd0);
          chk("rst dm_stall", 32'(bus.dm_stall), 32'd0);
          chk("rst im_do", bus.im_do, 32'h0000_0013);
          pend_v = 1'b0;
          return;
        end
        if (w == rdy_at) begin
          f = 2'd0;
          break;
        end
      end
      step();
      if (f == 2'd0 && !we) v = ext(rd >> (8 * lane), n, sgn);
    end else begin
      f = 2'd2;
    end
    pend_v = 1'b1; pend_f = f; pend_d = v;
  endtask

  task automatic resp_lit(input string name, input logic [31:0] d, input logic [1:0] f);
    idle();
    #3;
    chk({name, " valid"}, 32'(bus.dm_valid), 32'd1);
    chk({name, " do"}, bus.dm_do, d);
    chk({name, " fault"}, 32'(bus.dm_fault), 32'(f));
  endtask

  task automatic zero_cnt();
    idle(); idle();
    stall_cnt = 0; ioen_cnt = 0; valid_cnt = 0;
  endtask

  logic [31:0] bnd [5];
  logic [31:0] a;
  logic [1:0]  sz;

  initial begin
    pend_v = 1'b0; pend_f = 2'd0; pend_d = 32'd0;
    exp_valid = 1'b0; exp_stall = 1'b0; exp_io_en = 1'b0; exp_io_chk = 1'b0;
    bus.im_addr = 32'd0; bus.im_data = 32'd0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.dm_addr = 32'd0; bus.dm_size = 2'd0; bus.is_signed = 1'b0; bus.dm_di = 32'd0;
    bus.io_data_read = 32'd0; bus.io_ready = 1'b0;
    bnd[0] = RB + 32'd1023; bnd[1] = RB + 32'd1024; bnd[2] = RB - 32'd1;
    bnd[3] = IB + 32'd256;  bnd[4] = IB - 32'd4;

    repeat (3) @(posedge clk);
    #2;
    chk("reset im_do", bus.im_do, 32'h0000_0013);
    chk("reset dm_do", bus.dm_do, 32'd0);
    chk("reset dm_valid", 32'(bus.dm_valid), 32'd0);
    chk("reset dm_fault", 32'(bus.dm_fault), 32'd0);
    chk("reset io_en", 32'(bus.io_en), 32'd0);
    chk("reset io_we", 32'(bus.io_we), 32'd0);
    chk("reset io_be", 32'(bus.io_be), 32'd0);
    chk("reset io_addr", 32'(bus.io_addr), 32'd0);
    chk("reset io_data_write", bus.io_data_write, 32'd0);
    @(posedge clk);
    #1 resetb = 1'b1;

    for (int w = 0; w < 256; w++) txn(1'b1, RB + 32'(4 * w), 2'd2, 1'b0, $urandom, 0, 0);

    zero_cnt();
    txn(1'b1, 32'h1000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 0);
    resp_lit("st word", 32'd0, 2'd0);
    txn(1'b0, 32'h1000_0013, 2'd0, 1'b1, 32'd0, 0, 0);
    resp_lit("ld byte s", 32'hFFFF_FFDE, 2'd0);
    txn(1'b0, 32'h1000_0010, 2'd1, 1'b0, 32'd0, 0, 0);
    resp_lit("ld half u", 32'h0000_BEEF, 2'd0);
    chk("ram stall count", 32'(stall_cnt), 32'd0);

    txn(1'b0, 32'h1000_0011, 2'd1, 1'b0, 32'd0, 0, 0);
    resp_lit("ld half mis", 32'd0, 2'd1);
    txn(1'b1, 32'h1000_0011, 2'd1, 1'b0, 32'h0000_1234, 0, 0);
    resp_lit("st half mis", 32'd0, 2'd1);
    txn(1'b0, 32'h1000_0010, 2'd2, 1'b0, 32'd0, 0, 0);
    resp_lit("ram unchanged", 32'hDEAD_BEEF, 2'd0);
    txn(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'd0, 0, 0);
    resp_lit("unmapped", 32'd0, 2'd2);

    zero_cnt();
    txn(1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h0000_005A, 4, 0);
    resp_lit("io st", 32'd0, 2'd0);
    idle();
    chk("io st stall cycles", 32'(stall_cnt), 32'd5);
    chk("io st io_en cycles", 32'(ioen_cnt), 32'd4);
    chk("io st valid pulses", 32'(valid_cnt), 32'd1);

    zero_cnt();
    txn(1'b0, 32'h8000_0020, 2'd2, 1'b0, 32'd0, 0, 0);
    resp_lit("io timeout", 32'd0, 2'd3);
    idle();
    chk("timeout io_en cycles", 32'(ioen_cnt), 32'd4);
    chk("timeout valid pulses", 32'(valid_cnt), 32'd1);

    txn(1'b0, 32'h8000_0040, 2'd2, 1'b0, 32'd0, 0, 2);
    idle(); idle();
    resetb = 1'b1;
    txn(1'b0, 32'h1000_0010, 2'd2, 1'b0, 32'd0, 0, 0);
    resp_lit("after reset", 32'hDEAD_BEEF, 2'd0);

    zero_cnt();
    txn(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'd0, 1, 0);
    txn(1'b0, 32'h1000_0010, 2'd2, 1'b0, 32'd0, 0, 0);
    idle(); idle();
    chk("b2b io_en cycles", 32'(ioen_cnt), 32'd1);
    chk("b2b valid pulses", 32'(valid_cnt), 32'd2);
    chk("b2b stall cycles", 32'(stall_cnt), 32'd2);

    for (int k = 0; k < 400; k++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = RB + 32'($urandom_range(0, 1023));
        5, 6:          a = IB + 32'($urandom_range(0, 255));
        7:             a = 32'($urandom_range(0, 32'hFFF));
        8:             a = bnd[$urandom_range(0, 4)];
        default:       a = $urandom;
      endcase
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
          $urandom_range(1, 6), 0);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
